// File: rtl/pipe_pkg.sv
// Shared pipeline types: decoded control word, EX-stage register image and bubble constants.
package pipe_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [1:0] WR_SRC_ALU = 2'b00;
  localparam logic [1:0] WR_SRC_MEM = 2'b01;
  localparam logic [1:0] WR_SRC_PC4 = 2'b10;

  typedef struct packed {
    logic [3:0] alu_op;
    logic [4:0] br_op;
    logic [2:0] dm_ctrl;
    logic [1:0] ru_data_wr_src;
    logic       ru_wr;
    logic       dm_wr;
    logic       alu_a_src;
    logic       alu_b_src;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  typedef struct packed {
    logic        valid;
    ctrl_t       ctrl;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } ex_t;

  localparam ex_t EX_BUBBLE = '0;

  typedef enum logic [1:0] {ActHold, ActFlush, ActBubble, ActLoad} action_e;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between the load in EX and the instruction in ID.
module load_use_detect
  import pipe_pkg::*;
(
  input  logic       ex_valid_i,
  input  ctrl_t      ex_ctrl_i,
  input  logic [4:0] ex_rd_i,
  input  logic       id_valid_i,
  input  logic       id_use_rs1_i,
  input  logic [4:0] id_rs1_i,
  input  logic       id_use_rs2_i,
  input  logic [4:0] id_rs2_i,
  output logic       load_use_o
);

  logic ex_is_load;
  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    // x0 is hard-wired, so a load targeting it can never feed a consumer.
    ex_is_load = ex_valid_i & ex_ctrl_i.ru_wr & (ex_ctrl_i.ru_data_wr_src == WR_SRC_MEM) &
                 (ex_rd_i != 5'd0);
    rs1_hit    = id_use_rs1_i & (id_rs1_i == ex_rd_i);
    rs2_hit    = id_use_rs2_i & (id_rs2_i == ex_rd_i);
    load_use_o = ex_is_load & id_valid_i & (rs1_hit | rs2_hit);
  end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with hold, flush, load-use bubble insertion and event counters.
module id_ex_reg
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  ctrl_t       id_ctrl,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_pc4,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        stall_i,
  input  logic        flush_i,
  output ctrl_t       ex_ctrl,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_pc4,
  output logic [31:0] ex_rs1_data,
  output logic [31:0] ex_rs2_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [4:0]  ex_rd,
  output logic        stall_o,
  output logic [15:0] cnt_lu,
  output logic [15:0] cnt_flush
);

  ex_t         ex_q, ex_d;
  logic [15:0] cnt_lu_q, cnt_lu_d;
  logic [15:0] cnt_flush_q, cnt_flush_d;
  logic        load_use;
  action_e     action;

  load_use_detect u_load_use_detect (
    .ex_valid_i   (ex_q.valid),
    .ex_ctrl_i    (ex_q.ctrl),
    .ex_rd_i      (ex_q.rd),
    .id_valid_i   (id_valid),
    .id_use_rs1_i (id_use_rs1),
    .id_rs1_i     (id_rs1),
    .id_use_rs2_i (id_use_rs2),
    .id_rs2_i     (id_rs2),
    .load_use_o   (load_use)
  );

  always_comb begin
    action      = ActLoad;
    ex_d        = ex_q;
    cnt_lu_d    = cnt_lu_q;
    cnt_flush_d = cnt_flush_q;

    if (stall_i)       action = ActHold;
    else if (flush_i)  action = ActFlush;
    else if (load_use) action = ActBubble;

    unique case (action)
      ActHold: ;
      ActFlush: begin
        ex_d        = EX_BUBBLE;
        cnt_flush_d = sat_inc(cnt_flush_q);
      end
      ActBubble: begin
        ex_d     = EX_BUBBLE;
        cnt_lu_d = sat_inc(cnt_lu_q);
      end
      ActLoad: begin
        ex_d.valid    = id_valid;
        // Empty slots carry data through but must never write state downstream.
        ex_d.ctrl     = id_valid ? id_ctrl : CTRL_BUBBLE;
        ex_d.pc       = id_pc;
        ex_d.pc4      = id_pc4;
        ex_d.rs1_data = id_rs1_data;
        ex_d.rs2_data = id_rs2_data;
        ex_d.imm      = id_imm;
        ex_d.rs1      = id_rs1;
        ex_d.rs2      = id_rs2;
        ex_d.rd       = id_rd;
      end
      default: ;
    endcase

    // A flush squashes the branch shadow, so upstream must advance rather than hold.
    stall_o = (stall_i | load_use) & ~flush_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q        <= EX_BUBBLE;
      cnt_lu_q    <= '0;
      cnt_flush_q <= '0;
    end else begin
      ex_q        <= ex_d;
      cnt_lu_q    <= cnt_lu_d;
      cnt_flush_q <= cnt_flush_d;
    end
  end

  assign ex_ctrl     = ex_q.ctrl;
  assign ex_valid    = ex_q.valid;
  assign ex_pc       = ex_q.pc;
  assign ex_pc4      = ex_q.pc4;
  assign ex_rs1_data = ex_q.rs1_data;
  assign ex_rs2_data = ex_q.rs2_data;
  assign ex_imm      = ex_q.imm;
  assign ex_rs1      = ex_q.rs1;
  assign ex_rs2      = ex_q.rs2;
  assign ex_rd       = ex_q.rd;
  assign cnt_lu      = cnt_lu_q;
  assign cnt_flush   = cnt_flush_q;

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-low.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  synchronous active-low reset.
REQ-004 id_ctrl  in  ctrl_t (18)  decoded control from decode: ALUOp[4], BrOp[5], DMCtrl[3], RUDataWrSrc[2], RuWr, DMWr, AluASrc, AluBSrc.
REQ-005 id_valid  in  1  decode slot holds a real instruction.
REQ-006 id_pc, id_pc4, id_rs1_data, id_rs2_data, id_imm  in  32 each  PC, PC+4, register operands, generated immediate.
REQ-007 id_rs1, id_rs2, id_rd  in  5 each  register indices; id_use_rs1, id_use_rs2  in  1 each  operand actually read.
REQ-008 stall_i  in  1  downstream hold request; flush_i  in  1  squash from taken branch/jump resolved in EX.
REQ-009 ex_ctrl, ex_valid, ex_pc, ex_pc4, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd  out  registered copies of the id_* fields.
REQ-010 stall_o  out  1  combinational hold for PC and IF/ID register.
REQ-011 cnt_lu, cnt_flush  out  16 each  saturating event counters.

Function
REQ-012 Per clk edge, exactly one action SHALL occur, priority: reset > hold > flush > bubble > load.
REQ-013 hold (stall_i=1): all ex_* registers and counters SHALL keep their value; flush_i ignored that cycle.
REQ-014 flush (flush_i=1, stall_i=0): ex_* SHALL become a bubble; cnt_flush increments.
REQ-015 bubble: every ex_* field SHALL be zero (ex_valid=0, RuWr=0, DMWr=0, BrOp=00000).
REQ-016 load_use SHALL be 1 when ex_valid & ex_ctrl.RuWr & ex_ctrl.RUDataWrSrc=01 & ex_rd!=0 & id_valid & ((id_use_rs1 & id_rs1=ex_rd) | (id_use_rs2 & id_rs2=ex_rd)).
REQ-017 bubble action (load_use=1, no hold/flush): ex_* SHALL become a bubble and cnt_lu increments; the ID instruction stays upstream.
REQ-018 load: ex_* SHALL capture id_*; if id_valid=0 the control fields SHALL still be forced to bubble values.
REQ-019 stall_o SHALL equal (stall_i | load_use) & ~flush_i, same cycle, no register.
REQ-020 Latency: one cycle from id_* to ex_*; a load-use hazard SHALL cost exactly one bubble.
REQ-021 Counters SHALL saturate at 16'hFFFF and never wrap.
REQ-022 flush and load_use together: flush SHALL win; cnt_lu SHALL not increment.
REQ-023 rd=x0 SHALL never create a hazard.

Reset
REQ-024 rst_n=0 at clk edge SHALL zero all ex_* outputs and both counters, regardless of stall_i/flush_i.
REQ-025 Reset mid-hold or mid-bubble SHALL discard the pending instruction; first post-reset edge performs a normal action.
REQ-026 stall_o during reset SHALL evaluate from the zeroed ex_* state (i.e. 0 unless stall_i).

Structure
REQ-027 Shared package pipe_pkg SHALL hold ctrl_t packed struct, opcode constants, RUDataWrSrc encodings (ALU=00, MEM=01, PC4=10) and CTRL_BUBBLE constant.
REQ-028 Hazard comparison SHALL live in sub-module load_use_detect (pure combinational); registers and counters in id_ex_reg.
REQ-029 No latches; all state in one always_ff keyed on clk.

Verification
REQ-030 Load x5 then add x6,x5,x7 (id_use_rs1=1, id_rs1=5): stall_o=1 one cycle, ex_valid=0 next edge, cnt_lu 0->1, add reaches EX one cycle later.
REQ-031 Load x0 then instruction reading x0: stall_o=0, no bubble, cnt_lu=0.
REQ-032 flush_i=1 with load_use=1: ex_* zero, cnt_flush=1, cnt_lu=0, stall_o=0.
REQ-033 stall_i=1 for 3 cycles with flush_i=1 in cycle 2: ex_* unchanged all 3 cycles, cnt_flush unchanged.
REQ-034 Preload cnt_lu to 16'hFFFE via 65534 hazards, two more hazards: cnt_lu=16'hFFFF, stays.
REQ-035 rst_n=0 for one edge during stall_i=1 with ex_valid=1: all ex_* and counters zero after edge.
